irq_prio_router: RTL and testbench

- Second-generation Dock interrupt router. Routes tile INT channels and NMIs to CPU INT/NMI lines.
- Each CPU line arbitrates independently, so several lines can be active at once. The single-global-active restriction no longer applies.
- Adds per-source priority, a per-source level/edge mode, per-line acknowledge, and vector/status readback over the cfg bus.
- Sits between the tile slot IRQ pins and the CPU socket, on the Dock cfg bus.

---
 rtl/irq_prio_router_pkg.sv | 31 +++
 rtl/irq_line_arbiter.sv | 60 ++++++
 rtl/irq_prio_router.sv | 144 ++++++++++++++
 tb/tb_irq_prio_router.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_prio_router_pkg.sv
// Route entry layout, status base address and source/slot id helpers shared by the router.
// Types and constants only: no latency, no flow control.
package irq_prio_router_pkg;

   localparam int EN_BIT   = 7;
   localparam int EDGE_BIT = 6;
   localparam int PRIO_LSB = 4;
   localparam int IDX_LSB  = 0;
   localparam int PRIO_W   = 2;
   localparam int IDX_W    = 4;
   localparam int ID_W     = 7;

   localparam logic [7:0] STATUS_BASE = 8'h80;

   typedef struct packed {
      logic              en;
      logic              edge_mode;
      logic [PRIO_W-1:0] prio;
      logic [IDX_W-1:0]  idx;
   } route_entry_t;

   function automatic int src_id(input int slot, input int ch, input int nch);
      return slot * nch + ch;
   endfunction

   // INT ids are packed per slot; NMI ids follow the INT block, one per slot.
   function automatic int slot_of(input int id, input int nsrc, input int nch);
      return (id < nsrc) ? id / nch : id - nsrc;
   endfunction

endpackage

// File: rtl/irq_line_arbiter.sv
// Per-CPU-line non-preemptive arbiter: highest priority wins, ties go to the lowest source id.
// Grant lands one edge after pending; on release the line idles exactly one cycle; no backpressure.
module irq_line_arbiter
   import irq_prio_router_pkg::*;
#(
   parameter int NSRC = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NSRC-1:0]    pend,
   input  logic [2*NSRC-1:0]  prio,
   input  logic [NSRC-1:0]    mine,
   input  logic               ack,
   output logic               active,
   output logic [ID_W-1:0]    active_id,
   output logic               ack_hit
);

   logic              found;
   logic [PRIO_W-1:0] best_prio;
   logic [ID_W-1:0]   best_id;
   logic              hold;

   always_comb begin
      found     = 1'b0;
      best_prio = '0;
      best_id   = '0;
      hold      = 1'b0;
      // Scan downwards with >= so an equal-priority lower id overrides.
      for (int s = NSRC - 1; s >= 0; s--) begin
         if (pend[s] && mine[s] && (!found || prio[2*s +: 2] >= best_prio)) begin
            found     = 1'b1;
            best_prio = prio[2*s +: 2];
            best_id   = ID_W'(s);
         end
      end
      for (int s = 0; s < NSRC; s++) begin
         if (active_id == ID_W'(s)) hold = pend[s] & mine[s];
      end
   end

   assign ack_hit = ack & active;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         active    <= 1'b0;
         active_id <= '0;
      end else if (active) begin
         // Releasing never grants in the same edge, giving the one idle cycle.
         if (!hold) begin
            active    <= 1'b0;
            active_id <= '0;
         end
      end else if (found) begin
         active    <= 1'b1;
         active_id <= best_id;
      end
   end

endmodule

// File: rtl/irq_prio_router.sv
// Routes tile INT/NMI requests to CPU INT/NMI lines with per-source priority, level/edge mode and acks.
// Req to line output is 2 edges, ack to slot_ack 1 edge, cfg read data 1 edge; no backpressure.
module irq_prio_router
   import irq_prio_router_pkg::*;
#(
   parameter int NUM_SLOTS       = 3,
   parameter int NUM_TILE_INT_CH = 2,
   parameter int NUM_CPU_INT     = 2,
   parameter int NUM_CPU_NMI     = 1,
   parameter int CFG_ADDR_WIDTH  = 8,
   parameter int NMI_MASKS_INT   = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0] tile_int_req,
   input  logic [NUM_SLOTS-1:0]                 tile_nmi_req,
   input  logic [NUM_CPU_INT+NUM_CPU_NMI-1:0]   irq_ack,
   output logic [NUM_CPU_INT-1:0]               cpu_int,
   output logic [NUM_CPU_NMI-1:0]               cpu_nmi,
   output logic [NUM_SLOTS-1:0]                 slot_ack,
   input  logic                                 cfg_wr_en,
   input  logic                                 cfg_rd_en,
   input  logic [CFG_ADDR_WIDTH-1:0]            cfg_addr,
   input  logic [31:0]                          cfg_wdata,
   output logic [31:0]                          cfg_rdata
);

   localparam int NSRC  = NUM_SLOTS * NUM_TILE_INT_CH;
   localparam int NTOT  = NSRC + NUM_SLOTS;
   localparam int NLINE = NUM_CPU_INT + NUM_CPU_NMI;

   route_entry_t        entry_q [NTOT];
   logic [NTOT-1:0]     req, req_q, edge_q, pend, in_rng, clr;
   logic [NTOT-1:0]     mine [NLINE];
   logic [2*NTOT-1:0]   prio;
   logic [NLINE-1:0]    line_act, ack_hit;
   logic [ID_W-1:0]     line_id [NLINE];
   logic [NUM_SLOTS-1:0] slot_ack_n;
   logic [31:0]         rd_val;
   logic                nmi_mask;
   logic                unused_wdata;

   assign req          = {tile_nmi_req, tile_int_req};
   assign unused_wdata = |cfg_wdata[31:8];

   always_comb begin
      in_rng = '0;
      pend   = '0;
      prio   = '0;
      for (int s = 0; s < NTOT; s++) begin
         in_rng[s] = (s >= NSRC) ? (int'(entry_q[s].idx) < NUM_CPU_NMI)
                                 : (int'(entry_q[s].idx) < NUM_CPU_INT);
         prio[2*s +: 2] = entry_q[s].prio;
         pend[s] = entry_q[s].en & in_rng[s] & (entry_q[s].edge_mode ? edge_q[s] : req_q[s]);
      end
   end

   // INT entries index the INT lines, NMI entries index the NMI lines.
   always_comb begin
      for (int l = 0; l < NLINE; l++) begin
         mine[l] = '0;
         for (int s = 0; s < NTOT; s++) begin
            if (l < NUM_CPU_INT)
               mine[l][s] = (s < NSRC) && entry_q[s].en && (int'(entry_q[s].idx) == l);
            else
               mine[l][s] = (s >= NSRC) && entry_q[s].en && (int'(entry_q[s].idx) == l - NUM_CPU_INT);
         end
      end
   end

   for (genvar l = 0; l < NLINE; l++) begin : g_line
      irq_line_arbiter #(.NSRC(NTOT)) u_arb (
         .clk       (clk),
         .rst_n     (rst_n),
         .pend      (pend),
         .prio      (prio),
         .mine      (mine[l]),
         .ack       (irq_ack[l]),
         .active    (line_act[l]),
         .active_id (line_id[l]),
         .ack_hit   (ack_hit[l])
      );
   end

   always_comb begin
      clr        = '0;
      slot_ack_n = '0;
      for (int l = 0; l < NLINE; l++) begin
         for (int s = 0; s < NTOT; s++) begin
            if (ack_hit[l] && line_id[l] == ID_W'(s)) begin
               clr[s] = 1'b1;
               for (int k = 0; k < NUM_SLOTS; k++) begin
                  if (slot_of(s, NSRC, NUM_TILE_INT_CH) == k) slot_ack_n[k] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      rd_val = '0;
      for (int s = 0; s < NTOT; s++) begin
         if (cfg_addr == CFG_ADDR_WIDTH'(s)) rd_val = {24'h0, entry_q[s]};
      end
      for (int l = 0; l < NLINE; l++) begin
         if (cfg_addr == CFG_ADDR_WIDTH'(int'(STATUS_BASE) + l))
            rd_val = {24'h0, line_act[l], (line_act[l] ? line_id[l] : ID_W'(0))};
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int s = 0; s < NTOT; s++) entry_q[s] <= '0;
         req_q     <= '0;
         edge_q    <= '0;
         slot_ack  <= '0;
         cfg_rdata <= '0;
      end else begin
         req_q    <= req;
         slot_ack <= slot_ack_n;
         // A fresh rising edge beats a same-cycle ack clear.
         for (int s = 0; s < NTOT; s++) begin
            if (!entry_q[s].en || !entry_q[s].edge_mode || !in_rng[s])
               edge_q[s] <= 1'b0;
            else
               edge_q[s] <= (req[s] & ~req_q[s]) | (edge_q[s] & ~clr[s]);
         end
         for (int s = 0; s < NTOT; s++) begin
            if (cfg_wr_en && cfg_addr == CFG_ADDR_WIDTH'(s)) begin
               entry_q[s].en        <= cfg_wdata[EN_BIT];
               entry_q[s].edge_mode <= cfg_wdata[EDGE_BIT];
               entry_q[s].prio      <= cfg_wdata[PRIO_LSB +: PRIO_W];
               entry_q[s].idx       <= cfg_wdata[IDX_LSB +: IDX_W];
            end
         end
         if (cfg_rd_en) cfg_rdata <= rd_val;
      end
   end

   assign nmi_mask = (NMI_MASKS_INT != 0) && (|line_act[NLINE-1:NUM_CPU_INT]);
   assign cpu_int  = line_act[NUM_CPU_INT-1:0] & ~{NUM_CPU_INT{nmi_mask}};
   assign cpu_nmi  = line_act[NLINE-1:NUM_CPU_INT];

endmodule

// File: tb/tb_irq_prio_router.sv
// Table-driven bench for irq_prio_router with a scoreboard queue of expected outputs per edge.
module tb_irq_prio_router;
   import irq_prio_router_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  tile_int_req;
   logic [2:0]  tile_nmi_req;
   logic [2:0]  irq_ack;
   logic [1:0]  cpu_int;
   logic [0:0]  cpu_nmi;
   logic [2:0]  slot_ack;
   logic        cfg_wr_en, cfg_rd_en;
   logic [7:0]  cfg_addr;
   logic [31:0] cfg_wdata, cfg_rdata;

   irq_prio_router dut (
      .clk(clk), .rst_n(rst_n), .tile_int_req(tile_int_req), .tile_nmi_req(tile_nmi_req),
      .irq_ack(irq_ack), .cpu_int(cpu_int), .cpu_nmi(cpu_nmi), .slot_ack(slot_ack),
      .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [7:0]  addr;
      logic [31:0] wdat;
      logic [5:0]  ireq;
      logic [2:0]  nreq;
      logic [2:0]  ack;
      logic [1:0]  e_int;
      logic        e_nmi;
      logic [2:0]  e_sack;
      logic [7:0]  e_rd;
      string       nm;
   } vec_t;

   typedef struct {
      string       nm;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   vec_t tbl[$];
   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         0:       return {30'h0, cpu_int};
         1:       return {31'h0, cpu_nmi};
         2:       return {29'h0, slot_ack};
         default: return cfg_rdata;
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         0:       return "cpu_int";
         1:       return "cpu_nmi";
         2:       return "slot_ack";
         default: return "cfg_rdata";
      endcase
   endfunction

   task automatic push(input string nm, input int sel, input logic [31:0] exp);
      exp_t e;
      e.nm = nm; e.sel = sel; e.exp = exp;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      logic [31:0] act;
      while (sbq.size() > 0) begin
         e   = sbq.pop_front();
         act = actual(e.sel);
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", e.nm, sel_name(e.sel), act, e.exp);
         end
      end
   endtask

   task automatic push_outs(input string nm, input logic [1:0] ei, input logic en,
                            input logic [2:0] es);
      push(nm, 0, {30'h0, ei});
      push(nm, 1, {31'h0, en});
      push(nm, 2, {29'h0, es});
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      drain();
   endtask

   task automatic add(input logic wr, input logic rd, input logic [7:0] addr,
                      input logic [31:0] wdat, input logic [5:0] ireq, input logic [2:0] nreq,
                      input logic [2:0] ack, input logic [1:0] ei, input logic en,
                      input logic [2:0] es, input logic [7:0] erd, input string nm);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = addr; v.wdat = wdat; v.ireq = ireq; v.nreq = nreq;
      v.ack = ack; v.e_int = ei; v.e_nmi = en; v.e_sack = es; v.e_rd = erd; v.nm = nm;
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      cfg_wr_en = v.wr; cfg_rd_en = v.rd; cfg_addr = v.addr; cfg_wdata = v.wdat;
      tile_int_req = v.ireq; tile_nmi_req = v.nreq; irq_ack = v.ack;
      push_outs(v.nm, v.e_int, v.e_nmi, v.e_sack);
      if (v.rd) push(v.nm, 3, {24'h0, v.e_rd});
      step();
   endtask

   task automatic cyc(input logic [5:0] ireq, input logic [2:0] nreq, input logic [2:0] ack,
                      input logic [1:0] ei, input logic en, input logic [2:0] es, input string nm);
      cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
      tile_int_req = ireq; tile_nmi_req = nreq; irq_ack = ack;
      push_outs(nm, ei, en, es);
      step();
   endtask

   task automatic cfg_wr(input logic [7:0] addr, input logic [7:0] data);
      cfg_wr_en = 1'b1; cfg_addr = addr; cfg_wdata = {24'h0, data};
      step();
      cfg_wr_en = 1'b0;
   endtask

   task automatic rd_chk(input logic [7:0] addr, input logic [7:0] exp, input string nm);
      cfg_rd_en = 1'b1; cfg_addr = addr;
      push(nm, 3, {24'h0, exp});
      step();
      cfg_rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a2, a4;
      a2 = 8'(src_id(1, 0, 2));
      a4 = 8'(src_id(2, 0, 2));

      rst_n = 1'b1;
      tile_int_req = '0; tile_nmi_req = '0; irq_ack = '0;
      cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      repeat (3) @(negedge clk);
      push_outs("reset", 2'b00, 1'b0, 3'b000);
      push("reset", 3, 32'h0);
      drain();
      rst_n = 1'b0;

      //   wr    rd    addr   wdat           ireq       nreq    ack     int   nmi  sack    rd
      add(1'b0, 1'b1, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "rst_rd0");
      add(1'b0, 1'b1, 8'h80, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "rst_st0");
      // two lines active in parallel
      add(1'b1, 1'b0, 8'h00, 32'h80,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "par_w0");
      add(1'b1, 1'b0, a2,    32'h81,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "par_w2");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000101, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "par_e1");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000101, 3'b000, 3'b000, 2'b11, 1'b0, 3'b000, 8'h00, "par_e2");
      add(1'b0, 1'b1, 8'h80, 32'h0,         6'b000101, 3'b000, 3'b000, 2'b11, 1'b0, 3'b000, 8'h80, "par_st0");
      add(1'b0, 1'b1, 8'h81, 32'h0,         6'b000101, 3'b000, 3'b000, 2'b11, 1'b0, 3'b000, 8'h82, "par_st1");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b11, 1'b0, 3'b000, 8'h00, "par_drop1");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "par_drop2");
      add(1'b1, 1'b0, a2,    32'h00,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "par_off");
      // priority on a shared line, no preemption, single idle cycle
      add(1'b1, 1'b0, a4,    32'hB0,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "pri_w4");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b010001, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "pri_e1");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b010001, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "pri_grant");
      add(1'b0, 1'b1, 8'h80, 32'h0,         6'b010001, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h84, "pri_st");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "pri_drop");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "pri_idle");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "pri_regrant");
      add(1'b0, 1'b1, 8'h80, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h80, "pri_st0");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "pri_td1");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "pri_td2");
      add(1'b1, 1'b0, a4,    32'h00,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "pri_off");
      // edge mode: pulse held until ack, then released
      add(1'b1, 1'b0, 8'h01, 32'hC0,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "edg_w1");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000010, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "edg_pulse");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "edg_grant");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "edg_hold");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b001, 2'b01, 1'b0, 3'b001, 8'h00, "edg_ack");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "edg_clear");
      add(1'b1, 1'b0, 8'h01, 32'h00,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "edg_off");
      // NMI masks INT, INT state survives, NMI ack goes to its slot
      add(1'b1, 1'b0, 8'h07, 32'h80,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "nmi_w7");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "nmi_i1");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "nmi_pre");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b010, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "nmi_raise");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b010, 3'b000, 2'b00, 1'b1, 3'b000, 8'h00, "nmi_mask");
      add(1'b0, 1'b1, 8'h80, 32'h0,         6'b000001, 3'b010, 3'b100, 2'b00, 1'b1, 3'b010, 8'h80, "nmi_ack_st0");
      add(1'b0, 1'b1, 8'h82, 32'h0,         6'b000001, 3'b010, 3'b000, 2'b00, 1'b1, 3'b000, 8'h87, "nmi_st2");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b00, 1'b1, 3'b000, 8'h00, "nmi_drop");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "nmi_unmask");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, 8'h00, "nmi_td1");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "nmi_td2");
      add(1'b1, 1'b0, 8'h07, 32'h00,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "nmi_off");
      // out-of-range target is never granted and ignores acks
      add(1'b1, 1'b0, 8'h00, 32'h83,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "oor_w0");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "oor_e1");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "oor_int");
      add(1'b0, 1'b1, 8'h80, 32'h0,         6'b000001, 3'b000, 3'b001, 2'b00, 1'b0, 3'b000, 8'h00, "oor_st_ack");
      add(1'b0, 1'b0, 8'h00, 32'h0,         6'b000001, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "oor_sack");
      add(1'b1, 1'b0, 8'h00, 32'h00,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "oor_off");
      // readback, upper data bits, unmapped space
      add(1'b1, 1'b0, 8'h05, 32'h123456A5,  6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "rb_w5");
      add(1'b0, 1'b1, 8'h05, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'hA5, "rb_r5");
      add(1'b1, 1'b0, 8'h09, 32'hFF,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "rb_w9");
      add(1'b0, 1'b1, 8'h09, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "rb_r9");
      add(1'b0, 1'b1, 8'h83, 32'h0,         6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "rb_r83");
      add(1'b1, 1'b0, 8'h05, 32'h00,        6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, 8'h00, "rb_off");

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // same-cycle rising edge and ack clear: edge wins, source stays active
      cfg_wr(8'h01, 8'hC0);
      cyc(6'b000010, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, "ew_rise");
      cyc(6'b000000, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, "ew_grant");
      cyc(6'b000010, 3'b000, 3'b001, 2'b01, 1'b0, 3'b001, "ew_ack_rise");
      cyc(6'b000010, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, "ew_hold");
      cyc(6'b000000, 3'b000, 3'b001, 2'b01, 1'b0, 3'b001, "ew_ack");
      cyc(6'b000000, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, "ew_clear");
      cfg_wr(8'h01, 8'h00);

      // reset mid-operation kills an in-flight slot_ack pulse and all config
      cfg_wr(8'h00, 8'h80);
      cyc(6'b000001, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, "mr_e1");
      cyc(6'b000001, 3'b000, 3'b000, 2'b01, 1'b0, 3'b000, "mr_pre");
      cyc(6'b000001, 3'b000, 3'b001, 2'b01, 1'b0, 3'b001, "mr_sack");
      #2 rst_n = 1'b1;
      #1;
      push_outs("mr_async", 2'b00, 1'b0, 3'b000);
      drain();
      @(negedge clk);
      rst_n = 1'b0;
      cyc(6'b000001, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, "mr_after1");
      cyc(6'b000001, 3'b000, 3'b000, 2'b00, 1'b0, 3'b000, "mr_after2");
      rd_chk(8'h00, 8'h00, "mr_entry0");
      rd_chk(8'h80, 8'h00, "mr_status0");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
